// File: rtl/add_pkg.sv
// add_pkg: shared state encoding and nibble width for the add sequencer
package add_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int NIBBLE_W = 4;
endpackage

// File: rtl/add_seq_ctrl_if.sv
// add_seq_ctrl_if: request/result bus between datapath control and the add sequencer
interface add_seq_ctrl_if #(parameter int NIBBLES = 4);
    localparam int W = add_pkg::NIBBLE_W * NIBBLES;
    logic start;
    logic sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic busy;
    logic done;
    logic [W-1:0] result;
    logic cout;
    logic ovf;
    modport master(output start, sub, op_a, op_b, input busy, done, result, cout, ovf);
    modport slave(input start, sub, op_a, op_b, output busy, done, result, cout, ovf);
endinterface

// File: rtl/add.sv
// add: 4-bit adder with carry in and carry out
module add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: multi-nibble add/subtract sequenced through one shared 4-bit adder
module add_seq_ctrl
    import add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input logic clk,
    input logic rst_n,
    add_seq_ctrl_if.slave bus
);
    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    state_t state, next_state;
    logic [W-1:0] a_reg, b_reg, work, work_nx, result;
    logic [IW-1:0] idx;
    logic carry, cout, ovf, ovf_nx;
    logic [NIBBLE_W-1:0] add_a, add_b, add_s;
    logic add_cin, add_co;
    logic run, last, accept;

    assign run    = state == RUN;
    assign last   = idx == IW'(NIBBLES - 1);
    assign accept = bus.start && (state == IDLE || state == DONE);
    assign add_a  = run ? a_reg[NIBBLE_W*idx +: NIBBLE_W] : '0;
    assign add_b  = run ? b_reg[NIBBLE_W*idx +: NIBBLE_W] : '0;
    assign add_cin = run && carry;
    assign ovf_nx = (a_reg[W-1] == b_reg[W-1]) && (add_s[NIBBLE_W-1] != a_reg[W-1]);

    assign bus.busy   = run;
    assign bus.done   = state == DONE;
    assign bus.result = result;
    assign bus.cout   = cout;
    assign bus.ovf    = ovf;

    add u_add (
        .a(add_a),
        .b(add_b),
        .cin(add_cin),
        .s(add_s),
        .cout(add_co)
    );

    // work register with the current nibble replaced by the adder sum
    always_comb begin
        work_nx = work;
        work_nx[NIBBLE_W*idx +: NIBBLE_W] = add_s;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // next state: RUN walks the nibbles; IDLE and DONE both accept a new start
    always_comb begin
        next_state = run ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
    end

    // operand capture, nibble stepping, and publish on the last RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            work   <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_reg <= bus.op_a;
            b_reg <= bus.sub ? ~bus.op_b : bus.op_b;
            carry <= bus.sub;
            idx   <= '0;
        end else if (run) begin
            work  <= work_nx;
            carry <= add_co;
            idx   <= last ? idx : idx + 1'b1;
            if (last) begin
                result <= work_nx;
                cout   <= add_co;
                ovf    <= ovf_nx;
            end
        end
    end
endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Multi-precision add/subtract sequencer built around the team's 4-bit ripple adder `add` (a[3:0], b[3:0], cin -> s[3:0], cout). It takes one 4*NIBBLES-bit operation per start pulse and feeds it through the single adder one nibble per cycle, LSB nibble first, chaining the carry through a register. It reports the result, carry/borrow and signed overflow with a one-cycle done pulse. It sits between the datapath control logic and the shared adder, so wide arithmetic costs no extra adder area.

Parameters:
NIBBLES, 4, operand width in nibbles; the datapath width W = 4*NIBBLES; legal range 2..8.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled on clk rising edge when start_ok = 1.
sub  input  1  0 = A+B, 1 = A-B; sampled with start.
op_a  input  W  operand A; sampled with start.
op_b  input  W  operand B; sampled with start.
busy  output  1  high while nibbles are being processed (RUN state).
done  output  1  one-cycle pulse; result/cout/ovf valid from this cycle on.
result  output  W  registered sum/difference; holds until the next done.
cout  output  1  final carry out. For sub: 1 = no borrow (A >= B unsigned).
ovf  output  1  two's-complement signed overflow of the full-width operation.

Behaviour:
- Reset (rst_n = 0, asynchronous): state = IDLE; busy, done, result, cout, ovf = 0; index and carry registers = 0. Asserting reset mid-RUN aborts the operation with no done pulse.
- start_ok = (state == IDLE) || (state == DONE). start in any other state (RUN) is ignored and not queued.
- States:
  - IDLE: on start, capture the operands and go to RUN:
    - a_reg <= op_a.
    - b_reg <= sub ? ~op_b : op_b.
    - carry <= sub.
    - idx <= 0.
  - RUN (busy = 1): the adder sees a = a_reg[4*idx +: 4], b = b_reg[4*idx +: 4], cin = carry.
    - Each cycle: work[4*idx +: 4] <= s; carry <= adder cout; idx <= idx + 1.
    - When idx == NIBBLES-1, go to DONE.
    - On that last RUN cycle, also register ovf <= (a_msb == b_msb) && (s[3] != a_msb), where a_msb and b_msb are the MSBs of a_reg and b_reg.
  - DONE (done = 1, busy = 0): result <= work, and cout <= carry, both visible in this cycle. Design the publish registers so result, cout and ovf update on the transition into DONE.
    - With start: behave exactly as IDLE + start, i.e. back-to-back, next state RUN.
    - Without start: go to IDLE.
- Latency: start sampled at edge 0; RUN for cycles 1..NIBBLES; done high in cycle NIBBLES+1. Throughput is one operation per NIBBLES+1 cycles.
- result, cout and ovf change only on entry to DONE; they are never exposed as intermediate values.
- Width rules: idx is $clog2(NIBBLES) bits and never wraps during RUN. All arithmetic is modulo 2^W.
- Adder inputs are don't-care outside RUN; drive them to 0 to keep simulation clean.

Decomposition:
- Shared package (add_pkg): state enum {IDLE, RUN, DONE} encoded as 2 bits; the constant NIBBLE_W = 4.
- Sub-module: one instance of the existing 4-bit adder `add`, used unchanged.
- Everything else (operand registers, nibble mux, work register, FSM) lives in add_seq_ctrl.

Test Plan (NIBBLES = 4):
- Add with cross-nibble carries: sub = 0, A = 0x1234, B = 0x0FFF. Expect busy in cycles 1-4, done in cycle 5, result 0x2233, cout 0, ovf 0.
- Unsigned wrap: sub = 0, A = 0xFFFF, B = 0x0001. Expect result 0x0000, cout 1, ovf 0.
- Signed overflow: sub = 0, A = 0x7FFF, B = 0x0001, expect result 0x8000, cout 0, ovf 1. Then sub = 1, A = 0x8000, B = 0x0001, expect result 0x7FFF, cout 1, ovf 1.
- Borrow: sub = 1, A = 0x0000, B = 0x0001. Expect result 0xFFFF, cout 0 (borrow), ovf 0.
- start during RUN: start in cycle 2 with different operands. Expect it ignored, done only in cycle 5 with the first result. Then start in the DONE cycle. Expect it accepted, with the second done exactly 5 cycles later.
- Reset mid-operation: rst_n low in cycle 3. Expect busy, done, result, cout, ovf all 0 immediately, with no done pulse. After release, a new start completes normally.
